check_password: RTL and testbench

- Second stage of multi-user authentication; sits directly downstream of the ID checker.
- Arms when the ID checker asserts IDOK, and takes InternalID as the user's index.
- Collects a 6-digit hex password, one digit per EnterPswd pulse, MSB first.
- Fetches the stored password at that index from an internal password ROM, compares, and grants access or counts a failure. After MAX_TRIES consecutive failures it locks out for LOCK_CYCLES clocks.

---
 rtl/check_password_pkg.sv | 41 ++++
 rtl/check_password_rom.sv | 29 ++
 rtl/check_password.sv | 202 ++++++++++++++++++++
 tb/tb_check_password.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/check_password_pkg.sv
// Shared authentication definitions for the password stage.
// Holds the FSM state encoding, digit counts, ROM geometry, the user index
// map (same ordering as the ID ROM) and the digit-insertion helper.
package check_password_pkg;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StEntry   = 4'd1,
        StFetch   = 4'd2,
        StWait    = 4'd3,
        StCatch   = 4'd4,
        StCompare = 4'd5,
        StGranted = 4'd6,
        StFail    = 4'd7,
        StLocked  = 4'd8
    } authStateT;

    localparam int ID_DIGITS   = 4;
    localparam int PSWD_DIGITS = 6;
    localparam int ROM_DEPTH   = 32;
    localparam int PSWD_W      = 24;
    localparam int IDX_W       = $clog2(ROM_DEPTH);

    // User indices, identical ordering to the ID ROM.
    localparam logic [IDX_W-1:0] MEMBER1_IDX = 5'd0;
    localparam logic [IDX_W-1:0] MEMBER2_IDX = 5'd1;
    localparam logic [IDX_W-1:0] MEMBER3_IDX = 5'd2;
    localparam logic [IDX_W-1:0] MEMBER4_IDX = 5'd3;
    localparam logic [IDX_W-1:0] GUEST_IDX   = 5'd4;

    // Digits arrive MSB first: digit number cnt lands in nibble (5 - cnt).
    function automatic logic [PSWD_W-1:0] insertDigit(input logic [PSWD_W-1:0] cur,
                                                      input logic [2:0]        cnt,
                                                      input logic [3:0]        digit);
        logic [4:0] sh;
        sh = 5'((PSWD_DIGITS - 1 - int'(cnt)) * 4);
        return (cur & ~({{(PSWD_W-4){1'b0}}, 4'hF} << sh))
             | ({{(PSWD_W-4){1'b0}}, digit} << sh);
    endfunction

endpackage

// File: rtl/check_password_rom.sv
// Password ROM: 32 x 24, synchronous read with one registered output stage.
// Ports:
//   Clk  - system clock
//   Addr - user index
//   Data - stored password for Addr, valid one clock after Addr
module check_password_rom
    import check_password_pkg::*;
(
    input  logic              Clk,
    input  logic [IDX_W-1:0]  Addr,
    output logic [PSWD_W-1:0] Data
);

    function automatic logic [PSWD_W-1:0] romLookup(input logic [IDX_W-1:0] a);
        case (a)
            MEMBER1_IDX: return 24'hA54E32;
            MEMBER2_IDX: return 24'hEEE420;
            MEMBER3_IDX: return 24'hF24630;
            MEMBER4_IDX: return 24'hAAB431;
            GUEST_IDX:   return 24'hFFFFFF;
            default:     return '0;
        endcase
    endfunction

    always_ff @(posedge Clk) begin
        Data <= romLookup(Addr);
    end

endmodule

// File: rtl/check_password.sv
// Password check stage of multi-user authentication, downstream of the ID
// checker. Collects six hex digits, compares against the stored password of
// the user latched from InternalID, and grants access or counts a failure;
// MAX_TRIES consecutive failures cause a LOCK_CYCLES-clock lockout.
// Ports:
//   Clk, Reset     - clock, synchronous active-low reset
//   IDOK           - ID accepted (level); dropping it aborts / logs out
//   InternalID     - user ROM index, sampled when leaving Idle
//   InputSwitches  - current hex digit
//   EnterPswd      - single-cycle digit strobe
//   LogOutPulse    - single-cycle logout strobe
//   PswdOK         - access granted (level)
//   UserIndex      - authorized user index while PswdOK=1
//   BadPswd        - one-cycle pulse per failed compare
//   LockOut        - high during lockout
//   TriesUsed      - consecutive failures, saturating at MAX_TRIES
module check_password
    import check_password_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             IDOK,
    input  logic [IDX_W-1:0] InternalID,
    input  logic [3:0]       InputSwitches,
    input  logic             EnterPswd,
    input  logic             LogOutPulse,
    output logic             PswdOK,
    output logic [IDX_W-1:0] UserIndex,
    output logic             BadPswd,
    output logic             LockOut,
    output logic [1:0]       TriesUsed
);

    localparam logic [7:0]  WAIT_LOAD = 8'(WAIT_CYCLES);
    localparam logic [15:0] LOCK_LOAD = 16'(LOCK_CYCLES - 1);
    localparam logic [1:0]  TRIES_MAX = 2'(MAX_TRIES);
    localparam logic [2:0]  LAST_DIG  = 3'(PSWD_DIGITS - 1);

    authStateT         state, stateNext;
    logic [IDX_W-1:0]  index, indexNext;
    logic [PSWD_W-1:0] entryReg, entryNext;
    logic [PSWD_W-1:0] caughtWord, caughtNext;
    logic [PSWD_W-1:0] romWord;
    logic [2:0]        digitCnt, digitCntNext;
    logic [7:0]        waitCnt, waitCntNext;
    logic [15:0]       lockCnt, lockCntNext;
    logic              pswdOkNext, badPswdNext, lockOutNext;
    logic [IDX_W-1:0]  userIndexNext;
    logic [1:0]        triesNext;
    logic              abort;

    function automatic logic [1:0] satIncTries(input logic [1:0] t);
        return (t >= TRIES_MAX) ? TRIES_MAX : t + 2'd1;
    endfunction

    // The ROM reads the latched index every clock; the Wait countdown gives
    // it time to settle before Catch samples it.
    check_password_rom uRom (
        .Clk  (Clk),
        .Addr (index),
        .Data (romWord)
    );

    assign abort = LogOutPulse || !IDOK;

    always_comb begin
        stateNext     = state;
        indexNext     = index;
        entryNext     = entryReg;
        caughtNext    = caughtWord;
        digitCntNext  = digitCnt;
        waitCntNext   = waitCnt;
        lockCntNext   = lockCnt;
        pswdOkNext    = PswdOK;
        userIndexNext = UserIndex;
        badPswdNext   = 1'b0;
        lockOutNext   = LockOut;
        triesNext     = TriesUsed;

        case (state)
            StIdle: begin
                entryNext    = '0;
                digitCntNext = '0;
                if (IDOK) begin
                    indexNext = InternalID;
                    stateNext = StEntry;
                end
            end
            StEntry: begin
                // Logout beats a simultaneous final digit.
                if (abort) begin
                    stateNext = StIdle;
                end else if (EnterPswd) begin
                    entryNext    = insertDigit(entryReg, digitCnt, InputSwitches);
                    digitCntNext = digitCnt + 3'd1;
                    if (digitCnt == LAST_DIG) stateNext = StFetch;
                end
            end
            StFetch: begin
                if (abort) begin
                    stateNext = StIdle;
                end else begin
                    waitCntNext = WAIT_LOAD;
                    stateNext   = StWait;
                end
            end
            StWait: begin
                if (abort)             stateNext   = StIdle;
                else if (waitCnt == 0) stateNext   = StCatch;
                else                   waitCntNext = waitCnt - 8'd1;
            end
            StCatch: begin
                if (abort) begin
                    stateNext = StIdle;
                end else begin
                    caughtNext = romWord;
                    stateNext  = StCompare;
                end
            end
            StCompare: begin
                if (abort) begin
                    stateNext = StIdle;
                end else if (entryReg == caughtWord) begin
                    pswdOkNext    = 1'b1;
                    userIndexNext = index;
                    triesNext     = '0;
                    stateNext     = StGranted;
                end else begin
                    badPswdNext = 1'b1;
                    triesNext   = satIncTries(TriesUsed);
                    stateNext   = StFail;
                end
            end
            StFail: begin
                if (TriesUsed == TRIES_MAX) begin
                    lockOutNext = 1'b1;
                    lockCntNext = LOCK_LOAD;
                    stateNext   = StLocked;
                end else begin
                    entryNext    = '0;
                    digitCntNext = '0;
                    stateNext    = StEntry;
                end
            end
            StLocked: begin
                // All inputs except IDOK at expiry are ignored here.
                if (lockCnt == 0) begin
                    lockOutNext  = 1'b0;
                    triesNext    = '0;
                    entryNext    = '0;
                    digitCntNext = '0;
                    stateNext    = IDOK ? StEntry : StIdle;
                end else begin
                    lockCntNext = lockCnt - 16'd1;
                end
            end
            StGranted: begin
                if (abort) begin
                    pswdOkNext    = 1'b0;
                    userIndexNext = '0;
                    stateNext     = StIdle;
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= StIdle;
            index      <= '0;
            entryReg   <= '0;
            caughtWord <= '0;
            digitCnt   <= '0;
            waitCnt    <= '0;
            lockCnt    <= '0;
            PswdOK     <= 1'b0;
            UserIndex  <= '0;
            BadPswd    <= 1'b0;
            LockOut    <= 1'b0;
            TriesUsed  <= '0;
        end else begin
            state      <= stateNext;
            index      <= indexNext;
            entryReg   <= entryNext;
            caughtWord <= caughtNext;
            digitCnt   <= digitCntNext;
            waitCnt    <= waitCntNext;
            lockCnt    <= lockCntNext;
            PswdOK     <= pswdOkNext;
            UserIndex  <= userIndexNext;
            BadPswd    <= badPswdNext;
            LockOut    <= lockOutNext;
            TriesUsed  <= triesNext;
        end
    end

endmodule

// File: tb/tb_check_password.sv
// Directed bench for check_password: grant, retry, lockout, logout, abort,
// logout-vs-last-digit and reset-during-Wait scenarios.
module tb_check_password;
    import check_password_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       IDOK = 1'b0;
    logic [4:0] InternalID = '0;
    logic [3:0] InputSwitches = '0;
    logic       EnterPswd = 1'b0;
    logic       LogOutPulse = 1'b0;
    logic       PswdOK;
    logic [4:0] UserIndex;
    logic       BadPswd;
    logic       LockOut;
    logic [1:0] TriesUsed;

    int checks = 0;
    int failures = 0;
    int badSeen = 0;

    check_password dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .IDOK          (IDOK),
        .InternalID    (InternalID),
        .InputSwitches (InputSwitches),
        .EnterPswd     (EnterPswd),
        .LogOutPulse   (LogOutPulse),
        .PswdOK        (PswdOK),
        .UserIndex     (UserIndex),
        .BadPswd       (BadPswd),
        .LockOut       (LockOut),
        .TriesUsed     (TriesUsed)
    );

    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (BadPswd) badSeen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic enterDigit(input logic [3:0] d);
        EnterPswd = 1'b1;
        InputSwitches = d;
        tick();
        EnterPswd = 1'b0;
        InputSwitches = '0;
    endtask

    task automatic enterPswd(input logic [23:0] p);
        for (int i = 5; i >= 0; i--) enterDigit(p[i*4 +: 4]);
    endtask

    // Leaves Idle with a fresh index latched; ends in Entry.
    task automatic selectUser(input logic [4:0] id);
        InternalID = id;
        IDOK = 1'b1;
        tick();
    endtask

    task automatic logout(input string tag);
        LogOutPulse = 1'b1;
        tick();
        LogOutPulse = 1'b0;
        checkVal({tag, "_logout_ok"}, 32'(PswdOK), 0);
        checkVal({tag, "_logout_idx"}, 32'(UserIndex), 0);
        checkVal({tag, "_logout_state"}, 32'(dut.state), 32'(StIdle));
    endtask

    initial begin
        int lk;
        int guard;

        // Reset state
        ticks(2);
        checkVal("rst_ok", 32'(PswdOK), 0);
        checkVal("rst_idx", 32'(UserIndex), 0);
        checkVal("rst_bad", 32'(BadPswd), 0);
        checkVal("rst_lock", 32'(LockOut), 0);
        checkVal("rst_tries", 32'(TriesUsed), 0);
        Reset = 1'b1;

        // Member 1, correct password, latency of six edges
        selectUser(5'd0);
        badSeen = 0;
        enterPswd(24'hA54E32);
        ticks(5);
        checkVal("t1_early", 32'(PswdOK), 0);
        tick();
        checkVal("t1_ok", 32'(PswdOK), 1);
        checkVal("t1_idx", 32'(UserIndex), 0);
        checkVal("t1_nobad", 32'(badSeen), 0);
        checkVal("t1_tries", 32'(TriesUsed), 0);
        logout("t1");

        // Member 2, one wrong then correct
        selectUser(5'd1);
        badSeen = 0;
        enterPswd(24'hEEE421);
        ticks(6);
        checkVal("t2_bad", 32'(BadPswd), 1);
        checkVal("t2_tries1", 32'(TriesUsed), 1);
        checkVal("t2_ok0", 32'(PswdOK), 0);
        tick();
        checkVal("t2_badpulse", 32'(BadPswd), 0);
        checkVal("t2_badcount", 32'(badSeen), 1);
        checkVal("t2_entry", 32'(dut.state), 32'(StEntry));
        enterPswd(24'hEEE420);
        ticks(6);
        checkVal("t2_ok", 32'(PswdOK), 1);
        checkVal("t2_tries0", 32'(TriesUsed), 0);
        checkVal("t2_idx", 32'(UserIndex), 1);
        logout("t2");

        // Guest with all-F password, then logout
        selectUser(5'd4);
        enterPswd(24'hFFFFFF);
        ticks(6);
        checkVal("t4_ok", 32'(PswdOK), 1);
        checkVal("t4_idx", 32'(UserIndex), 4);
        logout("t4");

        // Drop IDOK mid-entry, stale digits must be gone
        selectUser(5'd2);
        enterDigit(4'hF);
        enterDigit(4'h2);
        enterDigit(4'h4);
        IDOK = 1'b0;
        tick();
        checkVal("t5_idle", 32'(dut.state), 32'(StIdle));
        enterDigit(4'h7);
        checkVal("t5_ignored", 32'(dut.state), 32'(StIdle));
        IDOK = 1'b1;
        tick();
        enterPswd(24'hF24630);
        ticks(6);
        checkVal("t5_ok", 32'(PswdOK), 1);
        checkVal("t5_idx", 32'(UserIndex), 2);
        logout("t5");

        // Logout together with the sixth digit: logout wins
        selectUser(5'd0);
        for (int i = 5; i >= 1; i--) enterDigit(4'(24'hA54E32 >> (i*4)));
        EnterPswd = 1'b1;
        InputSwitches = 4'h2;
        LogOutPulse = 1'b1;
        tick();
        EnterPswd = 1'b0;
        LogOutPulse = 1'b0;
        checkVal("t6_idle", 32'(dut.state), 32'(StIdle));
        badSeen = 0;
        ticks(8);
        checkVal("t6_nook", 32'(PswdOK), 0);
        checkVal("t6_nobad", 32'(badSeen), 0);

        // Member 4, three wrong passwords -> lockout
        IDOK = 1'b0;
        tick();
        selectUser(5'd3);
        for (int k = 1; k <= 3; k++) begin
            enterPswd(24'h000000);
            ticks(6);
            checkVal($sformatf("t3_bad%0d", k), 32'(BadPswd), 1);
            checkVal($sformatf("t3_tries%0d", k), 32'(TriesUsed), 32'(k));
            tick();
            checkVal($sformatf("t3_lock%0d", k), 32'(LockOut), (k == 3) ? 1 : 0);
        end
        lk = 1;
        guard = 0;
        while (LockOut && guard < 40) begin
            EnterPswd = guard[0];
            InputSwitches = 4'(guard);
            LogOutPulse = ~guard[0];
            tick();
            guard++;
            if (LockOut) lk++;
        end
        EnterPswd = 1'b0;
        LogOutPulse = 1'b0;
        InputSwitches = '0;
        checkVal("t3_lockcycles", 32'(lk), 16);
        checkVal("t3_tries_clr", 32'(TriesUsed), 0);
        checkVal("t3_entry", 32'(dut.state), 32'(StEntry));
        checkVal("t3_nook", 32'(PswdOK), 0);
        enterPswd(24'hAAB431);
        ticks(6);
        checkVal("t3_ok", 32'(PswdOK), 1);
        checkVal("t3_idx", 32'(UserIndex), 3);
        logout("t3");

        // Reset asserted during Wait
        selectUser(5'd0);
        enterPswd(24'h123456);
        ticks(6);
        checkVal("t7_tries1", 32'(TriesUsed), 1);
        tick();
        enterPswd(24'hA54E32);
        tick();
        checkVal("t7_wait", 32'(dut.state), 32'(StWait));
        Reset = 1'b0;
        tick();
        checkVal("t7_ok", 32'(PswdOK), 0);
        checkVal("t7_idx", 32'(UserIndex), 0);
        checkVal("t7_bad", 32'(BadPswd), 0);
        checkVal("t7_lock", 32'(LockOut), 0);
        checkVal("t7_tries", 32'(TriesUsed), 0);
        checkVal("t7_state", 32'(dut.state), 32'(StIdle));
        checkVal("t7_caught", 32'(dut.caughtWord), 0);
        checkVal("t7_entryreg", 32'(dut.entryReg), 0);
        checkVal("t7_waitcnt", 32'(dut.waitCnt), 0);
        checkVal("t7_digitcnt", 32'(dut.digitCnt), 0);
        Reset = 1'b1;
        IDOK = 1'b0;
        ticks(8);
        checkVal("t7_stay", 32'(PswdOK), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
